// File: rtl/simple_processor_pkg.sv
// Purpose: shared datapath width and ALU function encoding for the simple processor.
// Ports: none (package). func_t is a plain vector so that undefined codes can flow through unchanged.
// Encodings 4..7 are unassigned. The ALU returns 0 for them.
package simple_processor_pkg;
  parameter int DATA_WIDTH = 16;

  typedef logic [2:0] func_t;

  localparam func_t FUNC_AND = 3'd0;
  localparam func_t FUNC_OR  = 3'd1;
  localparam func_t FUNC_XOR = 3'd2;
  localparam func_t FUNC_NOT = 3'd3;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Purpose: instruction handshake from decode plus the operand/result bus to the ALU gate unit.
// Ports: instr_* (valid/ready + fields), alu_rs1/rs2/func (to ALU), alu_rd_data (from ALU).
// modport slave is the issue controller; modport master is the decode/ALU environment.
interface alu_issue_ctrl_if #(
  parameter int REG_AW = 3
);
  logic                                        instr_valid_i;
  logic                                        instr_ready_o;
  simple_processor_pkg::func_t                 instr_func_i;
  logic [REG_AW-1:0]                           instr_rd_i;
  logic [REG_AW-1:0]                           instr_rs1_i;
  logic [REG_AW-1:0]                           instr_rs2_i;
  logic [simple_processor_pkg::DATA_WIDTH-1:0] alu_rs1_data_o;
  logic [simple_processor_pkg::DATA_WIDTH-1:0] alu_rs2_data_o;
  simple_processor_pkg::func_t                 alu_func_o;
  logic [simple_processor_pkg::DATA_WIDTH-1:0] alu_rd_data_i;

  modport slave (
    input  instr_valid_i, instr_func_i, instr_rd_i, instr_rs1_i, instr_rs2_i, alu_rd_data_i,
    output instr_ready_o, alu_rs1_data_o, alu_rs2_data_o, alu_func_o
  );

  modport master (
    output instr_valid_i, instr_func_i, instr_rd_i, instr_rs1_i, instr_rs2_i, alu_rd_data_i,
    input  instr_ready_o, alu_rs1_data_o, alu_rs2_data_o, alu_func_o
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Purpose: issue one logic instruction at a time: read regfile, drive ALU, write result back.
// Latency: handshake in cycle N -> done_o in cycle N+3, ready again in N+4 (1 instr / 4 cycles).
// Backpressure: instr_ready_o only in IDLE and only when no direct load is requested that cycle.
// Ports: clk_i/rst_i (sync, active high), bus (slave modport), load_* init path, done_* report, dbg_* read.
module alu_issue_ctrl
  import simple_processor_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_issue_ctrl_if.slave       bus,
  input  logic                  load_en_i,
  input  logic [REG_AW-1:0]     load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  done_o,
  output logic [REG_AW-1:0]     done_rd_o,
  output logic [DATA_WIDTH-1:0] done_data_o,
  input  logic [REG_AW-1:0]     dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  func_t                 r_func;
  logic [REG_AW-1:0]     r_rd;
  logic [REG_AW-1:0]     r_rs1;
  logic [REG_AW-1:0]     r_rs2;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [DATA_WIDTH-1:0] r_result;
  func_t                 r_alu_func;
  logic                  r_done;
  logic [REG_AW-1:0]     r_done_rd;
  logic [DATA_WIDTH-1:0] r_done_data;
  logic                  w_ready;

  // A direct load owns the idle cycle, so load and issue never coincide.
  assign w_ready = (r_state == S_IDLE) && !load_en_i;

  assign bus.instr_ready_o  = w_ready;
  // Operand registers are loaded on the READ->EXEC edge, so the ALU sees
  // stable registered operands for the whole EXEC cycle and they hold afterwards.
  assign bus.alu_rs1_data_o = r_op1;
  assign bus.alu_rs2_data_o = r_op2;
  assign bus.alu_func_o     = r_alu_func;

  assign done_o      = r_done;
  assign done_rd_o   = r_done_rd;
  assign done_data_o = r_done_data;

  // Entry 0 is never written, so it reads as zero without a special case.
  assign dbg_data_o = r_regs[dbg_addr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_func      <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_result    <= '0;
      r_alu_func  <= '0;
      r_done      <= 1'b0;
      r_done_rd   <= '0;
      r_done_data <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_en_i) begin
            if (load_addr_i != '0) r_regs[load_addr_i] <= load_data_i;
          end else if (bus.instr_valid_i) begin
            r_func  <= bus.instr_func_i;
            r_rd    <= bus.instr_rd_i;
            r_rs1   <= bus.instr_rs1_i;
            r_rs2   <= bus.instr_rs2_i;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_op1      <= r_regs[r_rs1];
          r_op2      <= r_regs[r_rs2];
          r_alu_func <= r_func;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          // done_* are registered here so the pulse lands exactly in the WB cycle.
          r_result    <= bus.alu_rd_data_i;
          r_done      <= 1'b1;
          r_done_rd   <= r_rd;
          r_done_data <= bus.alu_rd_data_i;
          r_state     <= S_WB;
        end
        S_WB: begin
          if (r_rd != '0) r_regs[r_rd] <= r_result;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU gate interface.
- Accepts one logic instruction at a time over a valid/ready handshake.
- Holds the architectural register file and reads source operands from it.
- Drives operands and function to the combinational ALU gate unit, captures its result, and writes it back.
- Sits between the instruction decode stage and the ALU in the processor datapath.

Parameters:
NUM_REGS, 8, number of architectural registers; minimum 2; register 0 is hardwired zero.
REG_AW, $clog2(NUM_REGS), register address width; derived, not overridden.
(DATA_WIDTH and func_t come from simple_processor_pkg.)

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_i  input  1  synchronous reset, active high.
instr_valid_i  input  1  instruction fields are valid.
instr_ready_o  output  1  block can accept an instruction.
instr_func_i  input  func_t  operation: AND/OR/XOR/NOT.
instr_rd_i  input  REG_AW  destination register index.
instr_rs1_i  input  REG_AW  source register 1 index.
instr_rs2_i  input  REG_AW  source register 2 index.
load_en_i  input  1  direct register write strobe (initialisation path).
load_addr_i  input  REG_AW  direct write address.
load_data_i  input  DATA_WIDTH  direct write data.
alu_rs1_data_o  output  DATA_WIDTH  operand 1 to ALU.
alu_rs2_data_o  output  DATA_WIDTH  operand 2 to ALU.
alu_func_o  output  func_t  function select to ALU.
alu_rd_data_i  input  DATA_WIDTH  combinational result from ALU.
done_o  output  1  one-cycle pulse: writeback performed.
done_rd_o  output  REG_AW  destination index of the completed instruction; valid with done_o.
done_data_o  output  DATA_WIDTH  result written; valid with done_o.
dbg_addr_i  input  REG_AW  debug read address.
dbg_data_o  output  DATA_WIDTH  combinational read of regfile[dbg_addr_i]; 0 for index 0.

Behaviour:
- Clock and reset: one clock (clk_i). rst_i is synchronous and active-high.
- Reset clears the following to 0:
  - all registers;
  - operand and result registers;
  - alu_rs1_data_o, alu_rs2_data_o, alu_func_o;
  - done_o, done_rd_o, done_data_o.
- Reset forces the FSM to IDLE. Reset asserted in any state aborts the in-flight instruction with no writeback and no done_o.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE:
    - instr_ready_o = !load_en_i; it is 0 in all other states.
    - On instr_valid_i && instr_ready_o, latch func, rd, rs1 and rs2, then go to READ.
  - READ: latch regfile[rs1] and regfile[rs2] into operand registers; go to EXEC.
  - EXEC:
    - alu_* outputs are driven from the operand registers and latched func; these outputs are registered and hold their values outside EXEC.
    - Sample alu_rd_data_i into the result register; go to WB.
  - WB:
    - Write result to regfile[rd] unless rd == 0.
    - Assert done_o for exactly one cycle, with done_rd_o = rd and done_data_o = result (the result is reported even when rd == 0).
    - Go to IDLE.
- Latency and throughput: handshake in cycle N gives done_o in cycle N+3. Throughput is one instruction per 4 cycles. No back-to-back acceptance; ready returns in cycle N+4.
- NOT uses rs1 only. rs2 is still read and driven; the ALU ignores it.
- An unrecognised func value is passed through unchanged. The block writes back whatever the ALU returns (0 for an invalid func).
- Register 0: reads return 0; writes through WB or load are ignored.
- Load path:
  - Honoured only in IDLE: regfile[load_addr_i] <= load_data_i on the clock edge.
  - load_en_i in any other state is ignored.
  - load_en_i in IDLE blocks instruction acceptance that cycle, so there is no simultaneous load and issue.
- Read-after-write: a READ in the cycle after a WB or load to the same register sees the new value. The register file is a flop array, so there is no bypass need.
- dbg_data_o is purely combinational. It reflects a write one cycle after that write's clock edge.

Test Plan:
- Reset then dbg sweep: assert rst_i 2 cycles, release -> all dbg reads 0, instr_ready_o=1, done_o=0, alu_* outputs 0.
- Load then AND: load r1=0xF0F0, r2=0xFF00; issue AND rd=3 rs1=1 rs2=2 -> alu_func_o=AND in EXEC; done_o at N+3 with done_rd_o=3 and done_data_o=0xF000; dbg r3=0xF000.
- NOT and write to r0: r1=0x00FF, issue NOT rd=0 rs1=1 -> done_data_o=~0x00FF (DATA_WIDTH wide); dbg r0 stays 0.
- Chained dependency: XOR r4=r1^r2, then immediately OR r5=r4|r1 -> second instruction uses the updated r4; second done 4 cycles after first.
- Handshake rules: hold instr_valid_i high continuously -> accept only every 4th cycle. load_en_i asserted in IDLE with valid -> no accept, load performed. load_en_i during EXEC -> target register unchanged.
- Reset mid-operation: assert rst_i during EXEC -> no done_o, destination unchanged-from-reset (0), FSM back in IDLE with ready=1 next cycle.
